// File: rtl/pong_collision_scorer_pkg.sv
// Shared Pong definitions: bounce event codes and game_state encodings.
// ball_fsm and the score display decode these same values.
package pong_collision_scorer_pkg;

    localparam logic [1:0] BOUNCE_NONE   = 2'b00;
    localparam logic [1:0] BOUNCE_PADDLE = 2'b01;
    localparam logic [1:0] BOUNCE_WALL   = 2'b10;
    localparam logic [1:0] BOUNCE_CORNER = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_PLAY  = 2'b01;
    localparam logic [1:0] ST_POINT = 2'b10;
    localparam logic [1:0] ST_OVER  = 2'b11;

    // Map the paddle/wall hit flags to the bounce event code.
    function automatic logic [1:0] bounce_code(input logic paddle, input logic wall);
        logic [1:0] code;
        case ({paddle, wall})
            2'b10:   code = BOUNCE_PADDLE;
            2'b01:   code = BOUNCE_WALL;
            2'b11:   code = BOUNCE_CORNER;
            default: code = BOUNCE_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/pong_rect_overlap.sv
// Combinational axis-aligned rectangle overlap test.
// Rectangles are given by top-left corner plus compile-time size; the
// far-edge sums are one bit wider than the coordinates so they never wrap.
module pong_rect_overlap #(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 10,
    parameter int A_W     = 8,
    parameter int A_H     = 8,
    parameter int B_W     = 8,
    parameter int B_H     = 64
) (
    input  logic [X_WIDTH-1:0] a_x,
    input  logic [Y_WIDTH-1:0] a_y,
    input  logic [X_WIDTH-1:0] b_x,
    input  logic [Y_WIDTH-1:0] b_y,
    output logic               hit
);

    logic [X_WIDTH:0] a_x_e, b_x_e, a_x_end, b_x_end;
    logic [Y_WIDTH:0] a_y_e, b_y_e, a_y_end, b_y_end;

    // Strict overlap on both axes; touching edges do not count.
    always_comb begin
        a_x_e   = {1'b0, a_x};
        b_x_e   = {1'b0, b_x};
        a_y_e   = {1'b0, a_y};
        b_y_e   = {1'b0, b_y};
        a_x_end = a_x_e + (X_WIDTH+1)'(A_W);
        b_x_end = b_x_e + (X_WIDTH+1)'(B_W);
        a_y_end = a_y_e + (Y_WIDTH+1)'(A_H);
        b_y_end = b_y_e + (Y_WIDTH+1)'(B_H);
        hit     = (a_x_e < b_x_end) && (b_x_e < a_x_end) &&
                  (a_y_e < b_y_end) && (b_y_e < a_y_end);
    end

endmodule

// File: rtl/pong_collision_scorer.sv
// Pong collision detection, scoring and serve/point/game-over control.
// Evaluates ball against paddles, walls and goal lines once per frame in
// PLAY and reports a one-cycle bounce event or point award.
module pong_collision_scorer
    import pong_collision_scorer_pkg::*;
#(
    parameter int X_WIDTH     = 10,
    parameter int Y_WIDTH     = 10,
    parameter int SCREEN_X    = 640,
    parameter int SCREEN_Y    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_H    = 64,
    parameter int SCORE_WIDTH = 4,
    parameter int WIN_SCORE   = 9,
    parameter int COOLDOWN    = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic                   serve,
    input  logic [X_WIDTH-1:0]     ball_pos_x,
    input  logic [Y_WIDTH-1:0]     ball_pos_y,
    input  logic [X_WIDTH-1:0]     paddle_1_pos_x,
    input  logic [Y_WIDTH-1:0]     paddle_1_pos_y,
    input  logic [X_WIDTH-1:0]     paddle_2_pos_x,
    input  logic [Y_WIDTH-1:0]     paddle_2_pos_y,
    output logic [1:0]             bounce,
    output logic                   point_scored,
    output logic                   scorer,
    output logic [SCORE_WIDTH-1:0] score_1,
    output logic [SCORE_WIDTH-1:0] score_2,
    output logic [1:0]             game_state
);

    localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [CD_W-1:0]        CD_LOAD = CD_W'(COOLDOWN);
    localparam logic [SCORE_WIDTH-1:0] WIN     = SCORE_WIDTH'(WIN_SCORE);

    logic [1:0]             state_q, state_d;
    logic [1:0]             bounce_q, bounce_d;
    logic                   point_q, point_d;
    logic                   scorer_q, scorer_d;
    logic [SCORE_WIDTH-1:0] score_1_q, score_1_d;
    logic [SCORE_WIDTH-1:0] score_2_q, score_2_d;
    logic [CD_W-1:0]        cd_q, cd_d;

    logic                   hit_1, hit_2;
    logic                   wall, miss_left, miss_right, paddle_ok;
    logic [SCORE_WIDTH-1:0] new_score;

    pong_rect_overlap #(
        .X_WIDTH (X_WIDTH),
        .Y_WIDTH (Y_WIDTH),
        .A_W     (BALL_SIZE),
        .A_H     (BALL_SIZE),
        .B_W     (PADDLE_W),
        .B_H     (PADDLE_H)
    ) u_overlap_1 (
        .a_x (ball_pos_x),
        .a_y (ball_pos_y),
        .b_x (paddle_1_pos_x),
        .b_y (paddle_1_pos_y),
        .hit (hit_1)
    );

    pong_rect_overlap #(
        .X_WIDTH (X_WIDTH),
        .Y_WIDTH (Y_WIDTH),
        .A_W     (BALL_SIZE),
        .A_H     (BALL_SIZE),
        .B_W     (PADDLE_W),
        .B_H     (PADDLE_H)
    ) u_overlap_2 (
        .a_x (ball_pos_x),
        .a_y (ball_pos_y),
        .b_x (paddle_2_pos_x),
        .b_y (paddle_2_pos_y),
        .hit (hit_2)
    );

    // Edge detection at width+1 bits, then the next-state/score/cooldown update.
    always_comb begin
        wall       = (ball_pos_y == '0) ||
                     (({1'b0, ball_pos_y} + (Y_WIDTH+1)'(BALL_SIZE)) >= (Y_WIDTH+1)'(SCREEN_Y));
        miss_left  = (ball_pos_x == '0);
        miss_right = (({1'b0, ball_pos_x} + (X_WIDTH+1)'(BALL_SIZE)) >= (X_WIDTH+1)'(SCREEN_X));
        paddle_ok  = (hit_1 || hit_2) && (cd_q == '0);

        state_d   = state_q;
        bounce_d  = BOUNCE_NONE;
        point_d   = 1'b0;
        scorer_d  = scorer_q;
        score_1_d = score_1_q;
        score_2_d = score_2_q;
        cd_d      = cd_q;
        new_score = '0;

        if (frame_tick && (cd_q != '0)) begin
            cd_d = cd_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (serve) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    if (miss_left || miss_right) begin
                        point_d  = 1'b1;
                        scorer_d = miss_left;
                        cd_d     = '0;
                        if (miss_left) begin
                            new_score = (score_2_q >= WIN) ? score_2_q : score_2_q + 1'b1;
                            score_2_d = new_score;
                        end else begin
                            new_score = (score_1_q >= WIN) ? score_1_q : score_1_q + 1'b1;
                            score_1_d = new_score;
                        end
                        state_d = (new_score == WIN) ? ST_OVER : ST_POINT;
                    end else begin
                        bounce_d = bounce_code(paddle_ok, wall);
                        if (paddle_ok) cd_d = CD_LOAD;
                    end
                end
            end
            ST_POINT: begin
                if (serve) state_d = ST_PLAY;
            end
            default: begin
                if (serve) begin
                    state_d   = ST_IDLE;
                    score_1_d = '0;
                    score_2_d = '0;
                end
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bounce_q  <= BOUNCE_NONE;
            point_q   <= 1'b0;
            scorer_q  <= 1'b0;
            score_1_q <= '0;
            score_2_q <= '0;
            cd_q      <= '0;
        end else begin
            state_q   <= state_d;
            bounce_q  <= bounce_d;
            point_q   <= point_d;
            scorer_q  <= scorer_d;
            score_1_q <= score_1_d;
            score_2_q <= score_2_d;
            cd_q      <= cd_d;
        end
    end

    assign bounce       = bounce_q;
    assign point_scored = point_q;
    assign scorer       = scorer_q;
    assign score_1      = score_1_q;
    assign score_2      = score_2_q;
    assign game_state   = state_q;

endmodule

// File: tb/tb_pong_collision_scorer.sv
// Directed table-driven bench for pong_collision_scorer.
module tb_pong_collision_scorer;

    logic       clock = 1'b0;
    logic       reset, frame_tick, serve;
    logic [9:0] ball_pos_x, ball_pos_y;
    logic [9:0] paddle_1_pos_x, paddle_1_pos_y, paddle_2_pos_x, paddle_2_pos_y;
    logic [1:0] bounce, game_state;
    logic       point_scored, scorer;
    logic [3:0] score_1, score_2;

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    pong_collision_scorer #(
        .X_WIDTH     (10),
        .Y_WIDTH     (10),
        .SCREEN_X    (640),
        .SCREEN_Y    (480),
        .BALL_SIZE   (8),
        .PADDLE_W    (8),
        .PADDLE_H    (64),
        .SCORE_WIDTH (4),
        .WIN_SCORE   (9),
        .COOLDOWN    (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .serve          (serve),
        .ball_pos_x     (ball_pos_x),
        .ball_pos_y     (ball_pos_y),
        .paddle_1_pos_x (paddle_1_pos_x),
        .paddle_1_pos_y (paddle_1_pos_y),
        .paddle_2_pos_x (paddle_2_pos_x),
        .paddle_2_pos_y (paddle_2_pos_y),
        .bounce         (bounce),
        .point_scored   (point_scored),
        .scorer         (scorer),
        .score_1        (score_1),
        .score_2        (score_2),
        .game_state     (game_state)
    );

    typedef struct {
        logic       rst, tick, srv;
        logic [9:0] bx, by, p1x, p1y;
        logic [1:0] bnc;
        logic       pt, sc;
        logic [3:0] s1, s2;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp_v);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, sample 1ns after the rising edge.
    task automatic step(input logic rst, input logic tick, input logic srv,
                        input logic [9:0] bx, input logic [9:0] by,
                        input logic [9:0] p1x, input logic [9:0] p1y);
        @(negedge clock);
        reset          = rst;
        frame_tick     = tick;
        serve          = srv;
        ball_pos_x     = bx;
        ball_pos_y     = by;
        paddle_1_pos_x = p1x;
        paddle_1_pos_y = p1y;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_all(input int idx, input logic [1:0] bnc, input logic pt, input logic sc,
                              input logic [3:0] s1, input logic [3:0] s2, input logic [1:0] st);
        chk("bounce",       idx, 8'(bounce),       8'(bnc));
        chk("point_scored", idx, 8'(point_scored), 8'(pt));
        chk("scorer",       idx, 8'(scorer),       8'(sc));
        chk("score_1",      idx, 8'(score_1),      8'(s1));
        chk("score_2",      idx, 8'(score_2),      8'(s2));
        chk("game_state",   idx, 8'(game_state),   8'(st));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; frame_tick = 1'b0; serve = 1'b0;
        ball_pos_x = 10'd100; ball_pos_y = 10'd200;
        paddle_1_pos_x = 10'd10;  paddle_1_pos_y = 10'd400;
        paddle_2_pos_x = 10'd622; paddle_2_pos_y = 10'd400;

        //                 rst  tk   sv   bx    by    p1x  p1y   bnc pt sc s1 s2 st
        vecs.push_back('{1'b1,1'b0,1'b0,10'd100,10'd200,10'd10,10'd400, 2'd0,1'b0,1'b0,4'd0,4'd0,2'd0}); // 0 reset
        vecs.push_back('{1'b0,1'b0,1'b0,10'd100,10'd200,10'd10,10'd400, 2'd0,1'b0,1'b0,4'd0,4'd0,2'd0}); // 1 idle
        vecs.push_back('{1'b0,1'b1,1'b0,10'd0,  10'd200,10'd10,10'd400, 2'd0,1'b0,1'b0,4'd0,4'd0,2'd0}); // 2 tick in IDLE ignored
        vecs.push_back('{1'b0,1'b1,1'b1,10'd100,10'd0,  10'd10,10'd400, 2'd0,1'b0,1'b0,4'd0,4'd0,2'd1}); // 3 serve+tick: no eval
        vecs.push_back('{1'b0,1'b1,1'b0,10'd100,10'd0,  10'd10,10'd400, 2'd2,1'b0,1'b0,4'd0,4'd0,2'd1}); // 4 top wall
        vecs.push_back('{1'b0,1'b0,1'b0,10'd100,10'd0,  10'd10,10'd400, 2'd0,1'b0,1'b0,4'd0,4'd0,2'd1}); // 5 pulse ends
        vecs.push_back('{1'b0,1'b1,1'b0,10'd16, 10'd200,10'd10,10'd180, 2'd1,1'b0,1'b0,4'd0,4'd0,2'd1}); // 6 paddle 1
        for (int i = 0; i < 4; i++)
            vecs.push_back('{1'b0,1'b1,1'b0,10'd16,10'd200,10'd10,10'd180, 2'd0,1'b0,1'b0,4'd0,4'd0,2'd1}); // 7-10 cooldown
        vecs.push_back('{1'b0,1'b1,1'b0,10'd16, 10'd200,10'd10,10'd180, 2'd1,1'b0,1'b0,4'd0,4'd0,2'd1}); // 11 hit again
        for (int i = 0; i < 4; i++)
            vecs.push_back('{1'b0,1'b1,1'b0,10'd100,10'd200,10'd10,10'd400, 2'd0,1'b0,1'b0,4'd0,4'd0,2'd1}); // 12-15 drain
        vecs.push_back('{1'b0,1'b1,1'b0,10'd16, 10'd0,  10'd10,10'd0,   2'd3,1'b0,1'b0,4'd0,4'd0,2'd1}); // 16 corner top
        for (int i = 0; i < 4; i++)
            vecs.push_back('{1'b0,1'b1,1'b0,10'd100,10'd200,10'd10,10'd400, 2'd0,1'b0,1'b0,4'd0,4'd0,2'd1}); // 17-20 drain
        vecs.push_back('{1'b0,1'b1,1'b0,10'd16, 10'd472,10'd10,10'd440, 2'd3,1'b0,1'b0,4'd0,4'd0,2'd1}); // 21 corner bottom
        vecs.push_back('{1'b0,1'b1,1'b0,10'd16, 10'd472,10'd10,10'd440, 2'd2,1'b0,1'b0,4'd0,4'd0,2'd1}); // 22 wall only (cooldown)
        vecs.push_back('{1'b0,1'b1,1'b0,10'd0,  10'd200,10'd10,10'd400, 2'd0,1'b1,1'b1,4'd0,4'd1,2'd2}); // 23 left miss
        vecs.push_back('{1'b0,1'b0,1'b0,10'd0,  10'd200,10'd10,10'd400, 2'd0,1'b0,1'b1,4'd0,4'd1,2'd2}); // 24 scorer held
        vecs.push_back('{1'b0,1'b1,1'b0,10'd0,  10'd200,10'd10,10'd400, 2'd0,1'b0,1'b1,4'd0,4'd1,2'd2}); // 25 tick in POINT ignored
        vecs.push_back('{1'b0,1'b0,1'b1,10'd300,10'd200,10'd10,10'd400, 2'd0,1'b0,1'b1,4'd0,4'd1,2'd1}); // 26 serve
        vecs.push_back('{1'b0,1'b1,1'b0,10'd632,10'd100,10'd10,10'd400, 2'd0,1'b1,1'b0,4'd1,4'd1,2'd2}); // 27 right miss
        vecs.push_back('{1'b0,1'b0,1'b1,10'd300,10'd200,10'd10,10'd400, 2'd0,1'b0,1'b0,4'd1,4'd1,2'd1}); // 28 serve
        vecs.push_back('{1'b0,1'b1,1'b0,10'd631,10'd471,10'd10,10'd400, 2'd0,1'b0,1'b0,4'd1,4'd1,2'd1}); // 29 one short of both edges
        vecs.push_back('{1'b0,1'b1,1'b0,10'd300,10'd1,  10'd10,10'd400, 2'd0,1'b0,1'b0,4'd1,4'd1,2'd1}); // 30 y=1 not a wall
        vecs.push_back('{1'b0,1'b1,1'b0,10'd616,10'd420,10'd10,10'd400, 2'd1,1'b0,1'b0,4'd1,4'd1,2'd1}); // 31 paddle 2
        vecs.push_back('{1'b0,1'b0,1'b0,10'd300,10'd200,10'd10,10'd400, 2'd0,1'b0,1'b0,4'd1,4'd1,2'd1}); // 32 idle

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].tick, vecs[i].srv, vecs[i].bx, vecs[i].by, vecs[i].p1x, vecs[i].p1y);
            expect_all(i, vecs[i].bnc, vecs[i].pt, vecs[i].sc, vecs[i].s1, vecs[i].s2, vecs[i].st);
        end

        // Run player 1 up to 8 points, then the winning point goes straight to OVER.
        for (int k = 2; k <= 8; k++) begin
            step(1'b0, 1'b1, 1'b0, 10'd632, 10'd100, 10'd10, 10'd400);
            expect_all(100 + k, 2'd0, 1'b1, 1'b0, 4'(k), 4'd1, 2'd2);
            step(1'b0, 1'b0, 1'b1, 10'd300, 10'd200, 10'd10, 10'd400);
            chk("game_state", 120 + k, 8'(game_state), 8'd1);
        end
        step(1'b0, 1'b1, 1'b0, 10'd632, 10'd100, 10'd10, 10'd400);
        expect_all(200, 2'd0, 1'b1, 1'b0, 4'd9, 4'd1, 2'd3);
        step(1'b0, 1'b0, 1'b0, 10'd300, 10'd200, 10'd10, 10'd400);
        expect_all(201, 2'd0, 1'b0, 1'b0, 4'd9, 4'd1, 2'd3);
        step(1'b0, 1'b1, 1'b0, 10'd0, 10'd200, 10'd10, 10'd400);
        expect_all(202, 2'd0, 1'b0, 1'b0, 4'd9, 4'd1, 2'd3);
        step(1'b0, 1'b0, 1'b1, 10'd300, 10'd200, 10'd10, 10'd400);
        expect_all(203, 2'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0);

        // Reset in the cycle right after a tick that produced a bounce, with another tick pending.
        step(1'b0, 1'b0, 1'b1, 10'd300, 10'd200, 10'd10, 10'd400);
        chk("game_state", 300, 8'(game_state), 8'd1);
        step(1'b0, 1'b1, 1'b0, 10'd0, 10'd200, 10'd10, 10'd400);
        expect_all(301, 2'd0, 1'b1, 1'b1, 4'd0, 4'd1, 2'd2);
        step(1'b0, 1'b0, 1'b1, 10'd300, 10'd200, 10'd10, 10'd400);
        step(1'b0, 1'b1, 1'b0, 10'd100, 10'd0, 10'd10, 10'd400);
        expect_all(302, 2'd2, 1'b0, 1'b1, 4'd0, 4'd1, 2'd1);
        step(1'b1, 1'b1, 1'b0, 10'd0, 10'd200, 10'd10, 10'd400);
        expect_all(303, 2'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0);
        step(1'b0, 1'b0, 1'b0, 10'd300, 10'd200, 10'd10, 10'd400);
        expect_all(304, 2'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
